// File: rtl/h264_fetch_pkg.sv
// Shared definitions for the macroblock fetch responder.
// A 4:2:0 macroblock occupies 96 32-bit words: luma 0..63, Cb 64..79, Cr 80..95.
// Also provides the fetch FSM state type and the full-width address range check.
package h264_fetch_pkg;

    localparam int MB_WORDS = 96;
    localparam int Y_BASE   = 0;
    localparam int U_BASE   = 64;
    localparam int V_BASE   = 80;
    localparam int Y_WORDS  = 64;
    localparam int C_WORDS  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } fetch_state_e;

    // Full 32-bit compare so that large addresses never alias into the buffer.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/mb_read_pipe.sv
// Read-response delay line for the fetch responder.
// Each stage holds {valid, err, data}. Invalid stages keep their previous err/data,
// so the last stage naturally holds the most recent response between valid slots.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   in_valid_i     a served (not dropped) request enters the pipe this cycle
//   in_err_i       that request was out of range
//   in_data_i      buffer word read for that request
//   out_valid_o    response slot valid (last stage)
//   out_data_o     response word, forced to zero for out-of-range requests
//   empty_o        no valid entry anywhere in the pipe
module mb_read_pipe #(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid_i,
    input  logic        in_err_i,
    input  logic [31:0] in_data_i,
    output logic        out_valid_o,
    output logic [31:0] out_data_o,
    output logic        empty_o
);

    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] err_q;
    logic [31:0]        data_q [LATENCY];

    logic [LATENCY-1:0] src_valid_s;
    logic [LATENCY-1:0] src_err_s;
    logic [31:0]        src_data_s [LATENCY];

    // Source of each stage: the pipe input for stage 0, the previous stage otherwise.
    always_comb begin
        src_valid_s    = '0;
        src_err_s      = '0;
        for (int k = 0; k < LATENCY; k++) begin
            src_data_s[k] = 32'h0000_0000;
        end
        src_valid_s[0] = in_valid_i;
        src_err_s[0]   = in_err_i;
        src_data_s[0]  = in_data_i;
        for (int k = 1; k < LATENCY; k++) begin
            src_valid_s[k] = valid_q[k-1];
            src_err_s[k]   = err_q[k-1];
            src_data_s[k]  = data_q[k-1];
        end
    end

    // Shift register; err/data only advance with a valid entry so the output holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                data_q[k] <= 32'h0000_0000;
            end
        end else begin
            for (int k = 0; k < LATENCY; k++) begin
                valid_q[k] <= src_valid_s[k];
                if (src_valid_s[k]) begin
                    err_q[k]  <= src_err_s[k];
                    data_q[k] <= src_data_s[k];
                end else begin
                    err_q[k]  <= err_q[k];
                    data_q[k] <= data_q[k];
                end
            end
        end
    end

    assign out_valid_o = valid_q[LATENCY-1];
    // err and data are held together, so this stays stable across empty slots.
    assign out_data_o  = err_q[LATENCY-1] ? 32'h0000_0000 : data_q[LATENCY-1];
    assign empty_o     = ~(|valid_q);

endmodule

// File: rtl/mb_fetch_responder.sv
// Responder end of the macroblock fetch interface.
// Holds one macroblock loaded over a host write port and serves word reads with a
// configurable latency, optionally dropping every STALL_PERIOD-th issued request.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   load_valid   host write strobe
//   load_data    host write word (stored unchanged)
//   load_ready   buffer accepts a load word this cycle
//   load_done    one-cycle pulse after the last word of a macroblock is accepted
//   serve_en     requester active; fetch_addr is a request every cycle it is high
//   fetch_addr   word address of the request
//   data_word    response data (holds between valid slots)
//   data_valid   response slot valid, LATENCY cycles after the issuing cycle
//   addr_err     sticky flag: an out-of-range request was issued
module mb_fetch_responder
    import h264_fetch_pkg::*;
#(
    parameter int DEPTH        = MB_WORDS,
    parameter int LATENCY      = 1,
    parameter int STALL_PERIOD = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    output logic        load_ready,
    output logic        load_done,
    input  logic        serve_en,
    input  logic [31:0] fetch_addr,
    output logic [31:0] data_word,
    output logic        data_valid,
    output logic        addr_err
);

    localparam int WP_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SC_W     = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam int DROP_CNT = (STALL_PERIOD > 0) ? (STALL_PERIOD - 1) : 0;

    fetch_state_e    state_q, state_d;
    logic [WP_W-1:0] wptr_q, wptr_d;
    logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;
    logic            load_done_q, load_done_d;
    logic            addr_err_q, addr_err_d;
    logic [31:0]     mem_q [DEPTH];

    logic            accept_s;
    logic [WP_W-1:0] wr_idx_s;
    logic            last_word_s;
    logic            issue_s;
    logic            drop_s;
    logic            in_range_s;
    logic [31:0]     rd_data_s;
    logic            pipe_empty_s;

    // Load handshake: blocked while serving or while responses are still in flight.
    always_comb begin
        load_ready = 1'b0;
        if (rst) begin
            load_ready = 1'b0;
        end else begin
            case (state_q)
                IDLE:    load_ready = 1'b1;
                LOAD:    load_ready = 1'b1;
                READY:   load_ready = ~serve_en & pipe_empty_s;
                default: load_ready = 1'b0;
            endcase
        end
    end

    assign accept_s    = load_valid & load_ready;
    // A load accepted outside LOAD always starts a fresh macroblock at word 0.
    assign wr_idx_s    = (state_q == LOAD) ? wptr_q : {WP_W{1'b0}};
    assign last_word_s = (wr_idx_s == WP_W'(DEPTH - 1));
    assign issue_s     = (state_q == READY) & serve_en;
    assign in_range_s  = addr_in_range(fetch_addr, int'(DEPTH));

    // Request qualification: stall drop and buffer read for in-range addresses.
    always_comb begin
        drop_s    = 1'b0;
        rd_data_s = 32'h0000_0000;
        if (STALL_PERIOD > 0) begin
            drop_s = issue_s & (stall_cnt_q == SC_W'(DROP_CNT));
        end else begin
            drop_s = 1'b0;
        end
        if (in_range_s) begin
            rd_data_s = mem_q[fetch_addr[WP_W-1:0]];
        end else begin
            rd_data_s = 32'h0000_0000;
        end
    end

    // Next-state logic for the FSM, write pointer, stall counter and flags.
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        stall_cnt_d = stall_cnt_q;
        load_done_d = 1'b0;
        addr_err_d  = addr_err_q;

        if (accept_s) begin
            if (last_word_s) begin
                wptr_d      = {WP_W{1'b0}};
                load_done_d = 1'b1;
                state_d     = READY;
            end else begin
                wptr_d  = wr_idx_s + WP_W'(1);
                state_d = LOAD;
            end
        end else begin
            state_d = state_q;
        end

        // Counter only needed when the period exceeds one; period 1 drops everything.
        if (issue_s && (STALL_PERIOD > 1)) begin
            if (drop_s) begin
                stall_cnt_d = {SC_W{1'b0}};
            end else begin
                stall_cnt_d = stall_cnt_q + SC_W'(1);
            end
        end else begin
            stall_cnt_d = stall_cnt_q;
        end

        if (issue_s && !in_range_s) begin
            addr_err_d = 1'b1;
        end else begin
            addr_err_d = addr_err_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wptr_q      <= {WP_W{1'b0}};
            stall_cnt_q <= {SC_W{1'b0}};
            load_done_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            stall_cnt_q <= stall_cnt_d;
            load_done_q <= load_done_d;
            addr_err_q  <= addr_err_d;
        end
    end

    // Macroblock buffer; contents are not reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_q[wr_idx_s] <= load_data;
        end
    end

    mb_read_pipe #(
        .LATENCY (LATENCY)
    ) u_read_pipe (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (issue_s & ~drop_s),
        .in_err_i    (~in_range_s),
        .in_data_i   (rd_data_s),
        .out_valid_o (data_valid),
        .out_data_o  (data_word),
        .empty_o     (pipe_empty_s)
    );

    assign load_done = load_done_q;
    assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_mb_fetch_responder.sv
// Self-checking bench for mb_fetch_responder.
// Three instances share clock, reset and the load port:
//   a: LATENCY=1, no stalls   b: LATENCY=3, STALL_PERIOD=4   c: LATENCY=3, no stalls
module tb_mb_fetch_responder;
    import h264_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = 32'h0;

    logic        serve_a = 1'b0, serve_b = 1'b0, serve_c = 1'b0;
    logic [31:0] fetch_a = 32'h0, fetch_b = 32'h0, fetch_c = 32'h0;
    logic        load_ready_a, load_ready_b, load_ready_c;
    logic        load_done_a, load_done_b, load_done_c;
    logic [31:0] data_word_a, data_word_b, data_word_c;
    logic        data_valid_a, data_valid_b, data_valid_c;
    logic        addr_err_a, addr_err_b, addr_err_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mb_fetch_responder #(.DEPTH(MB_WORDS), .LATENCY(1), .STALL_PERIOD(0)) dut_a (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready_a), .load_done(load_done_a), .serve_en(serve_a),
        .fetch_addr(fetch_a), .data_word(data_word_a), .data_valid(data_valid_a),
        .addr_err(addr_err_a));

    mb_fetch_responder #(.DEPTH(MB_WORDS), .LATENCY(3), .STALL_PERIOD(4)) dut_b (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready_b), .load_done(load_done_b), .serve_en(serve_b),
        .fetch_addr(fetch_b), .data_word(data_word_b), .data_valid(data_valid_b),
        .addr_err(addr_err_b));

    mb_fetch_responder #(.DEPTH(MB_WORDS), .LATENCY(3), .STALL_PERIOD(0)) dut_c (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready_c), .load_done(load_done_c), .serve_en(serve_c),
        .fetch_addr(fetch_c), .data_word(data_word_c), .data_valid(data_valid_c),
        .addr_err(addr_err_c));

    typedef struct {
        logic        serve;
        logic [31:0] addr;
        logic        exp_valid;
        logic [31:0] exp_word;
        logic        exp_err;
    } vec_t;

    vec_t tbl [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, " load_ready_a"}, {31'd0, load_ready_a}, 32'd0);
        check({tag, " load_ready_c"}, {31'd0, load_ready_c}, 32'd0);
        check({tag, " load_done_a"},  {31'd0, load_done_a},  32'd0);
        check({tag, " data_valid_a"}, {31'd0, data_valid_a}, 32'd0);
        check({tag, " data_word_a"},  data_word_a,           32'd0);
        check({tag, " addr_err_a"},   {31'd0, addr_err_a},   32'd0);
        check({tag, " data_valid_c"}, {31'd0, data_valid_c}, 32'd0);
        check({tag, " data_word_c"},  data_word_c,           32'd0);
    endtask

    // Back-to-back load of n words; optionally checks the load_done pulse position.
    task automatic load_mb(input logic [31:0] base, input int n, input bit chk_done);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = base + 32'(i);
            tick();
            if (chk_done) begin
                check($sformatf("load_done_a w%0d", i), {31'd0, load_done_a}, {31'd0, 1'(i == MB_WORDS - 1)});
                check($sformatf("load_done_b w%0d", i), {31'd0, load_done_b}, {31'd0, 1'(i == MB_WORDS - 1)});
                check($sformatf("load_done_c w%0d", i), {31'd0, load_done_c}, {31'd0, 1'(i == MB_WORDS - 1)});
            end
        end
        load_valid = 1'b0;
        if (chk_done) begin
            tick();
            check("load_done_a pulse end", {31'd0, load_done_a}, 32'd0);
            check("load_ready_a after load", {31'd0, load_ready_a}, 32'd1);
        end
    endtask

    task automatic rd_a(input logic [31:0] addr, input logic [31:0] exp);
        serve_a = 1'b1;
        fetch_a = addr;
        tick();
        serve_a = 1'b0;
        check($sformatf("rd_a valid @%0d", addr), {31'd0, data_valid_a}, 32'd1);
        check($sformatf("rd_a word @%0d", addr), data_word_a, exp);
    endtask

    task automatic rd_c(input logic [31:0] addr, input logic [31:0] exp);
        serve_c = 1'b1;
        fetch_c = addr;
        tick();
        serve_c = 1'b0;
        tick();
        tick();
        check($sformatf("rd_c valid @%0d", addr), {31'd0, data_valid_c}, 32'd1);
        check($sformatf("rd_c word @%0d", addr), data_word_c, exp);
    endtask

    initial begin
        int          addr_next;
        int          delivered;
        int          attempts;
        int          nvalid;
        logic [31:0] last_word;
        logic        exp_v;

        // Single-cycle reads across plane boundaries, then out-of-range handling.
        tbl[0]  = '{1'b1, 32'(Y_BASE),               1'b1, 32'hA500_0000 + 32'(Y_BASE),               1'b0};
        tbl[1]  = '{1'b1, 32'(Y_BASE + Y_WORDS - 1), 1'b1, 32'hA500_0000 + 32'(Y_BASE + Y_WORDS - 1), 1'b0};
        tbl[2]  = '{1'b1, 32'(U_BASE),               1'b1, 32'hA500_0000 + 32'(U_BASE),               1'b0};
        tbl[3]  = '{1'b1, 32'(U_BASE + C_WORDS - 1), 1'b1, 32'hA500_0000 + 32'(U_BASE + C_WORDS - 1), 1'b0};
        tbl[4]  = '{1'b1, 32'(V_BASE),               1'b1, 32'hA500_0000 + 32'(V_BASE),               1'b0};
        tbl[5]  = '{1'b0, 32'd7,                     1'b0, 32'hA500_0000 + 32'(V_BASE),               1'b0};
        tbl[6]  = '{1'b1, 32'(V_BASE + C_WORDS - 1), 1'b1, 32'hA500_005F,                             1'b0};
        tbl[7]  = '{1'b1, 32'(MB_WORDS),             1'b1, 32'h0000_0000,                             1'b1};
        tbl[8]  = '{1'b0, 32'd0,                     1'b0, 32'h0000_0000,                             1'b1};
        tbl[9]  = '{1'b1, 32'hFFFF_FFFF,             1'b1, 32'h0000_0000,                             1'b1};
        tbl[10] = '{1'b1, 32'd3,                     1'b1, 32'hA500_0003,                             1'b1};
        tbl[11] = '{1'b1, 32'h8000_0000,             1'b1, 32'h0000_0000,                             1'b1};
        tbl[12] = '{1'b1, 32'd50,                    1'b1, 32'hA500_0032,                             1'b1};

        // Reset state.
        tick();
        tick();
        check_all_reset("in rst");
        rst = 1'b0;
        #1;
        check("load_ready_a after rst", {31'd0, load_ready_a}, 32'd1);
        check("load_ready_b after rst", {31'd0, load_ready_b}, 32'd1);

        // Test 1: first macroblock load.
        load_mb(32'hA500_0000, MB_WORDS, 1'b1);
        serve_a = 1'b1;
        fetch_a = 32'd0;
        #1;
        check("load_ready_a while serving", {31'd0, load_ready_a}, 32'd0);
        check("load_ready_b idle ready",    {31'd0, load_ready_b}, 32'd1);

        // Test 2: streaming sweep on the latency-1 instance.
        for (int i = 0; i < MB_WORDS; i++) begin
            fetch_a = 32'(i);
            tick();
            check($sformatf("sweep valid %0d", i), {31'd0, data_valid_a}, 32'd1);
            check($sformatf("sweep word %0d", i), data_word_a, 32'hA500_0000 + 32'(i));
        end
        check("addr_err_a after sweep", {31'd0, addr_err_a}, 32'd0);

        // Table: boundaries, hold on idle slots, out-of-range and sticky error.
        for (int r = 0; r < 13; r++) begin
            serve_a = tbl[r].serve;
            fetch_a = tbl[r].addr;
            tick();
            check($sformatf("tbl%0d valid", r), {31'd0, data_valid_a}, {31'd0, tbl[r].exp_valid});
            check($sformatf("tbl%0d word", r),  data_word_a,           tbl[r].exp_word);
            check($sformatf("tbl%0d err", r),   {31'd0, addr_err_a},   {31'd0, tbl[r].exp_err});
        end
        serve_a = 1'b0;
        tick();

        // Test 3: period-4 stalls, requester re-issues dropped addresses.
        addr_next = 0;
        delivered = 0;
        attempts  = 0;
        last_word = 32'h0000_0000;
        while (attempts < 20 && delivered < 8) begin
            attempts++;
            serve_b = 1'b1;
            fetch_b = 32'(addr_next);
            tick();
            serve_b = 1'b0;
            tick();
            tick();
            exp_v = ((attempts % 4) != 0);
            check($sformatf("stall issue%0d valid", attempts), {31'd0, data_valid_b}, {31'd0, exp_v});
            if (data_valid_b) begin
                check($sformatf("stall issue%0d word", attempts), data_word_b, 32'hA500_0000 + 32'(addr_next));
                last_word = 32'hA500_0000 + 32'(addr_next);
                addr_next++;
                delivered++;
            end else begin
                check($sformatf("stall issue%0d hold", attempts), data_word_b, last_word);
            end
        end
        check("stall delivered", 32'(delivered), 32'd8);
        check("stall attempts",  32'(attempts),  32'd10);

        // Test 5: serve_en drops with three requests in flight.
        nvalid = 0;
        for (int j = 0; j < 8; j++) begin
            if (j < 3) begin
                serve_c = 1'b1;
                fetch_c = 32'd20 + 32'(j);
            end else begin
                serve_c = 1'b0;
            end
            tick();
            if (data_valid_c) nvalid++;
            exp_v = (j >= 2 && j <= 4);
            check($sformatf("drain slot%0d valid", j), {31'd0, data_valid_c}, {31'd0, exp_v});
            if (exp_v) begin
                check($sformatf("drain slot%0d word", j), data_word_c, 32'hA500_0014 + 32'(j - 2));
            end
            if (j == 4) begin
                serve_c = 1'b0;
                #1;
                check("load_ready_c while draining", {31'd0, load_ready_c}, 32'd0);
            end
        end
        check("drain valid count", 32'(nvalid), 32'd3);
        check("load_ready_c drained", {31'd0, load_ready_c}, 32'd1);
        check("data_word_c held", data_word_c, 32'hA500_0016);

        // Second macroblock overwrites from word 0.
        load_mb(32'h5A00_0000, MB_WORDS, 1'b1);
        rd_a(32'd0, 32'h5A00_0000);
        rd_a(32'd95, 32'h5A00_005F);
        rd_c(32'd0, 32'h5A00_0000);

        // Test 6a: reset while serving (addr_err_a is still set from earlier).
        check("addr_err_a sticky", {31'd0, addr_err_a}, 32'd1);
        serve_a = 1'b1;
        fetch_a = 32'd5;
        tick();
        check("pre-rst valid_a", {31'd0, data_valid_a}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_all_reset("rst mid-serve");
        #1 rst = 1'b0;
        tick();
        check("serve in IDLE no valid", {31'd0, data_valid_a}, 32'd0);
        check("load_ready_a in IDLE",   {31'd0, load_ready_a}, 32'd1);
        serve_a = 1'b0;

        // Test 6b: reset after 40 load words, then a complete load.
        load_mb(32'h3C00_0000, 40, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_all_reset("rst mid-load");
        #1 rst = 1'b0;
        load_mb(32'hC300_0000, MB_WORDS, 1'b1);
        rd_a(32'd39, 32'hC300_0027);
        rd_a(32'd40, 32'hC300_0028);
        rd_a(32'd95, 32'hC300_005F);
        rd_c(32'd64, 32'hC300_0040);
        check("addr_err_a clear after reload", {31'd0, addr_err_a}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
